// File: rtl/sliced_logic_unit.sv
// -----------------------------------------------------------------------------
// sliced_logic_unit
//
// Bitwise logic unit for the 8-bit CPU datapath. It evaluates one of eight
// bitwise operations over WIDTH-bit operands, SLICE bits per clock, so a
// full operation takes NUM_SLICES = WIDTH/SLICE RUN cycles. Completion is
// signalled with a one-cycle done pulse. y and zero update only on that
// completion edge, so partial results are never visible.
//
// Parameters:
//   WIDTH  operand/result width; must be an integer multiple of SLICE
//   SLICE  bits evaluated per clock
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request a new operation (sampled only while idle)
//   op     operation select, latched on an accepted start
//            000 AND   001 OR    010 XOR    011 NAND
//            100 NOR   101 XNOR  110 NOT A  111 PASS A
//   a, b   operands, latched on an accepted start
//   busy   high while an operation is in progress
//   done   single-cycle pulse when y/zero are updated
//   y      result of the last completed operation
//   zero   high when the last completed result is zero
// -----------------------------------------------------------------------------
module sliced_logic_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  // At least one counter bit, even when a single slice covers the word.
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_y;
  // Internal result with the current slice merged in.
  logic [WIDTH-1:0] res_upd;

  // One shared "gate stage" applied to a SLICE-bit chunk.
  function automatic logic [SLICE-1:0] slice_op(
    input logic [2:0]       sel,
    input logic [SLICE-1:0] sa,
    input logic [SLICE-1:0] sb
  );
    logic [SLICE-1:0] r;
    case (sel)
      3'b000:  r = sa & sb;
      3'b001:  r = sa | sb;
      3'b010:  r = sa ^ sb;
      3'b011:  r = ~(sa & sb);
      3'b100:  r = ~(sa | sb);
      3'b101:  r = ~(sa ^ sb);
      3'b110:  r = ~sa;
      default: r = sa;
    endcase
    return r;
  endfunction

  // Select the operand slice addressed by the counter. A compare-per-slice
  // mux avoids an out-of-range array index when NUM_SLICES is not a power
  // of two.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        slice_a = a_q[i*SLICE +: SLICE];
        slice_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  assign slice_y = slice_op(op_q, slice_a, slice_b);

  // Merge the freshly computed slice into its position of the result word.
  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_merge
      assign res_upd[gi*SLICE +: SLICE] =
        (cnt_q == CNT_W'(gi)) ? slice_y : res_q[gi*SLICE +: SLICE];
    end
  endgenerate

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    y_d     = y_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Also taken in the done cycle, giving NUM_SLICES+1 cycle throughput.
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        // start is deliberately ignored here; inputs may change freely.
        res_d = res_upd;
        if (cnt_q == LAST_CNT) begin
          y_d     = res_upd;
          zero_d  = (res_upd == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign y    = y_q;
  assign zero = zero_q;

endmodule

// File: doc/sliced_logic_unit.md
Name: sliced_logic_unit

Overview:
- Parametrised successor to the fixed 4-bit quad gate packages: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Evaluates operands one SLICE-bit slice per clock, like a chain of 4-bit TTL gate packages sharing one gate stage, and reports completion with a start/busy/done handshake.
- Sits beside the ALU in the 8-bit CPU datapath and serves the logic instructions (AND/OR/XOR/NOT family). It also sets a zero flag for the flags register.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits evaluated per clock cycle.
- NUM_SLICES (derived, not overridable), WIDTH/SLICE, cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  3  operation select, latched on accepted start
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when y/zero are updated
- y  output  WIDTH  result; holds last completed result
- zero  output  1  high when last completed result == 0

Behaviour:
- Reset (async, rst=1): state=IDLE, slice counter=0, operand/op latches=0, y=0, zero=0, busy=0, done=0. Takes effect immediately, independent of clk. A reset mid-operation aborts it: no done pulse, and y returns to 0.
- Op encoding (bitwise over all WIDTH bits):
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR
  - 110 NOT A (b ignored), 111 PASS A (b ignored)
- FSM states: IDLE, RUN.
- IDLE -> RUN at a rising edge where start=1:
  - latch a, b, op; counter=0; clear internal result register; busy=1 from this edge.
- RUN, each edge:
  - compute slice [counter*SLICE +: SLICE] from the latched operands and write it into the internal result register.
  - if counter == NUM_SLICES-1: y <= full result (including this slice), zero <= (full result == 0), done <= 1, busy <= 0, state -> IDLE.
  - else counter <= counter+1.
- Latency: the accept edge is edge 0; done is high for exactly the cycle after edge NUM_SLICES. WIDTH=8, SLICE=4 gives 2 cycles.
- done is registered. It is cleared on the next edge unless another completion occurs, which is impossible in back-to-back operation.
- y and zero change only on a completion edge or reset. Partial results are never visible on y.
- start while busy=1 is ignored: no re-latch and no effect on the current op. Inputs a, b, op may change freely during RUN.
- start high during the done cycle (state already IDLE) is accepted on that edge. Maximum throughput is one operation per NUM_SLICES+1 cycles.
- start held high continuously: a new operation is accepted on every IDLE edge.
- NUM_SLICES==1 (WIDTH==SLICE): RUN lasts one cycle and completes on the first RUN edge.
- Counter width is clog2(NUM_SLICES), minimum 1 bit. It never exceeds NUM_SLICES-1.

Test Plan:
- Reset then idle (WIDTH=8, SLICE=4) -> y=0x00, zero=0, busy=0, done=0. Pulse start with op=001, a=0xC3, b=0x0A -> busy=1 for 2 cycles, then done pulses once, y=0xCB, zero=0.
- Legacy quad-OR equivalence (WIDTH=4, SLICE=4), op=001 -> done one cycle after start each time:
  - a=0xC, b=0xA -> y=0xE
  - a=0x0, b=0x5 -> y=0x5
  - a=0x0, b=0x0 -> y=0x0, zero=1
- All ops, WIDTH=8, a=0xF0, b=0x3C:
  - AND=0x30, OR=0xFC, XOR=0xCC, NAND=0xCF
  - NOR=0x03, XNOR=0x33, NOT A=0x0F, PASS A=0xF0
  - AND with b=0x0F -> y=0x00, zero=1.
- Busy protection: start op=000, a=0xFF, b=0x55; one cycle later assert start with a=0x00 and op=001 -> result y=0x55 after 2 cycles, with exactly one done pulse. Start in the done cycle (op=010, a=0xAA, b=0xFF) -> accepted; y=0x55 held until the next done, then y=0x55 (0xAA^0xFF).
- Reset mid-op: start OR 0x12|0x40, assert rst asynchronously between edges 1 and 2 -> outputs 0 immediately, no done pulse; after release the unit accepts a new start normally.
- WIDTH=16, SLICE=4: XOR a=0x1234, b=0xFFFF -> busy 4 cycles, done once, y=0xEDCB; y holds its previous value during RUN.
